imdct_window_ctrl: RTL
======================

Name: imdct_window_ctrl

Overview:
- Sequencer for the IMDCT windowing stage of the MP3 decoder.
- On `start`, walks all 32 subbands of one granule/channel. Per subband it issues 18 index-pair beats (0/1, 2/3 … 34/35), together with the subband base address and the effective block type.
- Waits for the overlap-add stage to report completion before moving to the next subband.
- Pulses `done` once the whole granule has been windowed.

Parameters:
- NUM_SB, 32, subbands per granule.
- BEATS, 18, index pairs per subband (36 samples / 2).
- SB_STRIDE, 18, base_address increment per subband.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to window one granule; sampled only in IDLE.
- block_type_in  in  2  granule block type (00 normal, 01 start, 10 short, 11 stop); latched on accepted start.
- mixed_block  in  1  mixed-block flag; latched on accepted start.
- beat_ready  in  1  windowing datapath can accept the current beat.
- overlap_done  in  1  one-cycle pulse from overlap-add: current subband finished.
- beat_valid  out  1  index_0/index_1/base_address/block_type valid (drives compute_done of datapath).
- index_0  out  6  even sample index 2k.
- index_1  out  6  odd sample index 2k+1.
- base_address  out  10  sb*SB_STRIDE.
- block_type  out  2  effective block type for current subband.
- sb  out  5  current subband number.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of granule.

Behaviour:
- Reset (rst_n=0, async): state IDLE; k=0, sb=0. All outputs 0: beat_valid, index_0, index_1, base_address, block_type, sb, busy, done.
- States: IDLE, RUN, WAIT_OV, FIN.

IDLE:
- `start`=1 latches block_type_in and mixed_block, clears sb and k, and moves to RUN.
- `start` in any other state is ignored; no queueing.

RUN:
- beat_valid=1; index_0=2k, index_1=2k+1; base_address=sb*18.
- Transfer occurs when beat_valid & beat_ready. On a transfer, k increments.
- With beat_ready=0, all beat outputs hold stable.
- A transfer at k=BEATS-1 (indices 34/35) clears k and moves to WAIT_OV. beat_valid drops the next cycle.

WAIT_OV:
- beat_valid=0. Only overlap_done is sampled.
- If sb<NUM_SB-1: sb increments and the state returns to RUN.
- If sb=NUM_SB-1: go to FIN.
- overlap_done in IDLE, RUN or FIN is ignored.

FIN:
- done=1 for exactly one cycle, busy=1, then IDLE.
- sb, base_address and block_type return to 0 in IDLE.

Effective block_type:
- Equals the latched type, except when mixed_block=1 and sb<2, where it is 00 (long window).

Latency:
- Accepted start at edge t gives beat_valid=1, indices 0/1, base 0 from edge t+1.
- Minimum subband time is 18 beats + 1 cycle WAIT_OV + the overlap_done delay.

Arithmetic:
- base_address is computed by an accumulator (+18 per subband, no multiplier). Maximum value is 558, no overflow in 10 bits.
- k is 5 bits, wraps via explicit clear at 17.

Reset mid-operation:
- Immediate abort to IDLE with all outputs 0.
- No done pulse; latched type is cleared.

Test Plan:
1. Reset then start, block_type_in=00, mixed=0, beat_ready=1, overlap_done 3 cycles after each WAIT_OV entry:
   - 18 beats per subband, indices 0/1 … 34/35.
   - base 0,18,…,558 for sb 0..31.
   - block_type=00 throughout.
   - Exactly one done pulse, then busy=0.
2. beat_ready toggles 1,0,0,1 pseudo-randomly during sb=5:
   - Indices and base=90 hold while ready=0.
   - No index skipped or repeated; exactly 18 transfers.
3. block_type_in=10, mixed=1:
   - block_type out=00 for sb 0,1.
   - block_type out=10 for sb 2..31.
4. start pulsed during RUN at sb=3; overlap_done pulsed during RUN:
   - Both ignored; sequence identical to scenario 1.
5. rst_n deasserted mid sb=7, beat k=9:
   - All outputs 0 immediately (async).
   - No done.
   - A fresh start restarts at sb=0, indices 0/1.
6. overlap_done held low 50 cycles in WAIT_OV at sb=31:
   - Stays in WAIT_OV, beat_valid=0, busy=1.
   - done follows 1 cycle after the overlap_done pulse.

Source files
------------

// File: rtl/imdct_window_ctrl.sv
// IMDCT windowing sequencer: walks 32 subbands per granule, issuing 18 index-pair
// beats per subband and waiting for overlap-add completion between subbands.
module imdct_window_ctrl #(
  parameter int NUM_SB    = 32,
  parameter int BEATS     = 18,
  parameter int SB_STRIDE = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] block_type_in,
  input  logic       mixed_block,
  input  logic       beat_ready,
  input  logic       overlap_done,
  output logic       beat_valid,
  output logic [5:0] index_0,
  output logic [5:0] index_1,
  output logic [9:0] base_address,
  output logic [1:0] block_type,
  output logic [4:0] sb,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_OV = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [4:0] sb_q, sb_d;
  logic [9:0] base_q, base_d;
  logic [1:0] type_q, type_d;
  logic       mixed_q, mixed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      sb_q    <= '0;
      base_q  <= '0;
      type_q  <= '0;
      mixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sb_q    <= sb_d;
      base_q  <= base_d;
      type_q  <= type_d;
      mixed_q <= mixed_d;
    end
  end

  // Beat handshake: a beat transfers on any rising edge where beat_valid and
  // beat_ready are both high; while beat_ready is low every beat output holds.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sb_d    = sb_q;
    base_d  = base_q;
    type_d  = type_q;
    mixed_d = mixed_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          type_d  = block_type_in;
          mixed_d = mixed_block;
          k_d     = '0;
          sb_d    = '0;
          base_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat_ready) begin
          if (k_q == 5'(BEATS - 1)) begin
            k_d     = '0;
            state_d = WAIT_OV;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      WAIT_OV: begin
        if (overlap_done) begin
          if (sb_q == 5'(NUM_SB - 1)) begin
            state_d = FIN;
          end else begin
            sb_d    = sb_q + 5'd1;
            base_d  = base_q + 10'(SB_STRIDE);
            state_d = RUN;
          end
        end
      end
      FIN: begin
        sb_d    = '0;
        base_d  = '0;
        type_d  = '0;
        mixed_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mixed blocks keep the two lowest subbands on the long window.
  always_comb begin
    beat_valid   = 1'b0;
    index_0      = '0;
    index_1      = '0;
    base_address = base_q;
    sb           = sb_q;
    block_type   = '0;
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
    dbg_state    = state_q;
    if (state_q != IDLE) begin
      block_type = (mixed_q && (sb_q < 5'd2)) ? 2'b00 : type_q;
    end
    if (state_q == RUN) begin
      beat_valid = 1'b1;
      index_0    = {k_q, 1'b0};
      index_1    = {k_q, 1'b1};
    end
  end

endmodule
